// File: rtl/nn_wbm_pkg.sv
// Shared types and default widths for the NN Wishbone initiator.
package nn_wbm_pkg;

    localparam int NN_WBM_ADDR_W = 32;
    localparam int NN_WBM_DATA_W = 32;
    // Width of the optional ack-timeout counter.
    localparam int NN_WBM_TO_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_e;

endpackage

// File: rtl/nn_wbm_timeout.sv
// Ack-timeout counter: cleared when a transfer starts, counts each BUS
// cycle, flags the last allowed cycle. Only built with NN_WBM_TIMEOUT_EN.
module nn_wbm_timeout
    import nn_wbm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_l,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // Terminal value is one less than the limit because the first BUS
    // cycle sees a count of zero.
    localparam logic [NN_WBM_TO_W-1:0] LAST = NN_WBM_TO_W'(TIMEOUT_CYCLES - 1);

    logic [NN_WBM_TO_W-1:0] cnt;

    // Count BUS cycles since the transfer was issued.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)    cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (en)   cnt <= cnt + 1'b1;
    end

    assign tc = en && (cnt == LAST);

endmodule

// File: rtl/nn_wb_master.sv
// Wishbone classic single-cycle initiator for the NN slave port.
// One valid/ready command -> one Wishbone read/write -> one response.
// Optional ack timeout: define NN_WBM_TIMEOUT_EN.
module nn_wb_master
    import nn_wbm_pkg::*;
#(
    parameter int ADDR_W         = NN_WBM_ADDR_W,
    parameter int DATA_W         = NN_WBM_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i
);

    wbm_state_e state, state_d;
    logic       cyc_q, rdy_q, rvld_q;
    logic       hs, done_ack, done_to, to_tc;

    assign hs       = (state == IDLE) && cmd_valid && rdy_q;
    assign done_ack = (state == BUS) && wbm_ack_i;
    assign done_to  = (state == BUS) && !wbm_ack_i && to_tc;

    // State register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_d;
    end

    // Next state: ack beats a same-cycle timeout.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (hs) state_d = BUS;
            BUS:     if (done_ack || done_to) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered handshake/bus outputs; cmd_ready stays low through reset
    // and rises on the first clock after release.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rdy_q     <= 1'b0;
            cyc_q     <= 1'b0;
            rvld_q    <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            rsp_dat   <= '0;
        end else begin
            rdy_q <= (state_d == IDLE);
            if (hs) begin
                cyc_q     <= 1'b1;
                wbm_we_o  <= cmd_we;
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_dat;
                wbm_sel_o <= cmd_sel;
            end
            if (done_ack || done_to) begin
                cyc_q    <= 1'b0;
                wbm_we_o <= 1'b0;
                rvld_q   <= 1'b1;
                rsp_dat  <= (done_ack && !wbm_we_o) ? wbm_dat_i : '0;
            end
            if ((state == RESP) && rsp_ready) rvld_q <= 1'b0;
        end
    end

    assign cmd_ready = rdy_q;
    assign rsp_valid = rvld_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;

`ifdef NN_WBM_TIMEOUT_EN
    logic err_q;

    nn_wbm_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_to (
        .clk   (clk),
        .rst_l (rst_l),
        .clr   (hs),
        .en    (state == BUS),
        .tc    (to_tc)
    );

    // Error flag follows the way the last transfer ended.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)                    err_q <= 1'b0;
        else if (done_ack || done_to)  err_q <= done_to;
    end

    assign rsp_err = err_q;
`else
    // Without the timeout BUS waits for ack forever; the limit is unused.
    logic unused_to;
    assign unused_to = ^TIMEOUT_CYCLES;
    assign to_tc     = 1'b0;
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_nn_wb_master.sv
// Directed self-checking bench for nn_wb_master.
module tb_nn_wb_master;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i = '0;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    nn_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_l(rst_l),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_rvld", rsp_valid, 0);
        chk("rst_rdy", cmd_ready, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_rdat", rsp_dat, 0);
        #9 rst_l = 1'b1;
        step();
        chk("rel_rdy", cmd_ready, 1);

        // Write, ack on first BUS cycle
        cmd_valid = 1; cmd_we = 1; cmd_adr = 32'h3000_0004;
        cmd_dat = 32'h3F80_0000; cmd_sel = 4'hF;
        wbm_ack_i = 1; wbm_dat_i = 32'hDEAD_BEEF; rsp_ready = 1;
        step();
        cmd_valid = 0;
        chk("wr_cyc", wbm_cyc_o, 1);
        chk("wr_stb", wbm_stb_o, 1);
        chk("wr_we", wbm_we_o, 1);
        chk("wr_adr", wbm_adr_o, 32'h3000_0004);
        chk("wr_dat", wbm_dat_o, 32'h3F80_0000);
        chk("wr_sel", wbm_sel_o, 4'hF);
        chk("wr_rdy_busy", cmd_ready, 0);
        chk("wr_rvld_early", rsp_valid, 0);
        step();
        wbm_ack_i = 0;
        chk("wr_cyc_drop", wbm_cyc_o, 0);
        chk("wr_we_drop", wbm_we_o, 0);
        chk("wr_rvld", rsp_valid, 1);
        chk("wr_rdat", rsp_dat, 0);
        chk("wr_err", rsp_err, 0);
        step();
        chk("wr_rvld_clr", rsp_valid, 0);
        chk("wr_rdy_back", cmd_ready, 1);

        // Read, 3 wait states, response back-pressured 5 cycles
        cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0010; cmd_sel = 4'hF;
        rsp_ready = 0;
        step();
        cmd_valid = 0;
        chk("rd_cyc1", wbm_cyc_o, 1);
        chk("rd_we", wbm_we_o, 0);
        chk("rd_adr", wbm_adr_o, 32'h3000_0010);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rd_cyc_wait", wbm_cyc_o, 1);
            chk("rd_rvld_wait", rsp_valid, 0);
        end
        wbm_ack_i = 1; wbm_dat_i = 32'h4040_0000;
        step();
        wbm_ack_i = 0; wbm_dat_i = 32'h1111_1111;
        chk("rd_cyc_drop", wbm_cyc_o, 0);
        for (int i = 0; i < 5; i++) begin
            chk("rd_rvld_hold", rsp_valid, 1);
            chk("rd_rdat_hold", rsp_dat, 32'h4040_0000);
            chk("rd_rdy_hold", cmd_ready, 0);
            chk("rd_err", rsp_err, 0);
            step();
        end
        chk("rd_rvld_last", rsp_valid, 1);
        rsp_ready = 1;
        step();
        chk("rd_rvld_clr", rsp_valid, 0);
        chk("rd_rdy_back", cmd_ready, 1);

        // Back-to-back: second cyc rises 3 cycles after the first
        cmd_valid = 1; cmd_we = 1; cmd_adr = 32'h3000_0020; wbm_ack_i = 1;
        step();
        chk("b2b_cyc_a", wbm_cyc_o, 1);
        chk("b2b_adr_a", wbm_adr_o, 32'h3000_0020);
        cmd_adr = 32'h3000_0024;
        step();
        chk("b2b_cyc_b", wbm_cyc_o, 0);
        chk("b2b_rvld_b", rsp_valid, 1);
        step();
        chk("b2b_cyc_c", wbm_cyc_o, 0);
        chk("b2b_rdy_c", cmd_ready, 1);
        step();
        cmd_valid = 0;
        chk("b2b_cyc_d", wbm_cyc_o, 1);
        chk("b2b_adr_d", wbm_adr_o, 32'h3000_0024);
        step();
        wbm_ack_i = 0;
        chk("b2b_rvld_e", rsp_valid, 1);
        step();
        chk("b2b_idle", cmd_ready, 1);

        // Spurious ack while idle
        wbm_ack_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("spur_rvld", rsp_valid, 0);
            chk("spur_cyc", wbm_cyc_o, 0);
        end
        wbm_ack_i = 0;

`ifdef NN_WBM_TIMEOUT_EN
        // Slave never acks: timeout after 4 BUS cycles
        cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0030; rsp_ready = 0;
        step();
        cmd_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("to_cyc", wbm_cyc_o, 1);
            step();
        end
        chk("to_cyc_drop", wbm_cyc_o, 0);
        chk("to_rvld", rsp_valid, 1);
        chk("to_err", rsp_err, 1);
        chk("to_rdat", rsp_dat, 0);
        rsp_ready = 1;
        step();
        step();
        // Ack on the terminal cycle wins
        cmd_valid = 1; rsp_ready = 0;
        step();
        cmd_valid = 0;
        for (int i = 0; i < 3; i++) step();
        chk("toa_cyc4", wbm_cyc_o, 1);
        wbm_ack_i = 1; wbm_dat_i = 32'h4080_0000;
        step();
        wbm_ack_i = 0;
        chk("toa_rvld", rsp_valid, 1);
        chk("toa_err", rsp_err, 0);
        chk("toa_rdat", rsp_dat, 32'h4080_0000);
        rsp_ready = 1;
        step();
        step();
`else
        // No timeout: BUS holds well past 4 cycles without ack
        cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0030;
        step();
        cmd_valid = 0;
        for (int i = 0; i < 10; i++) step();
        chk("nto_cyc", wbm_cyc_o, 1);
        chk("nto_rvld", rsp_valid, 0);
        wbm_ack_i = 1; wbm_dat_i = 32'h4080_0000;
        step();
        wbm_ack_i = 0;
        chk("nto_rdat", rsp_dat, 32'h4080_0000);
        chk("nto_err", rsp_err, 0);
        step();
`endif

        // Reset asserted mid-read
        cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0040; rsp_ready = 1;
        step();
        cmd_valid = 0;
        chk("rb_cyc_pre", wbm_cyc_o, 1);
        #2 rst_l = 1'b0;
        #1;
        chk("rb_cyc", wbm_cyc_o, 0);
        chk("rb_stb", wbm_stb_o, 0);
        chk("rb_rvld", rsp_valid, 0);
        chk("rb_adr", wbm_adr_o, 0);
        step();
        #2 rst_l = 1'b1;
        step();
        chk("rb_rdy", cmd_ready, 1);
        wbm_ack_i = 1; wbm_dat_i = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rb_no_rsp", rsp_valid, 0);
        end
        wbm_ack_i = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop if the sequence above ever stalls.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nn_wb_master.md
# nn_wb_master

Wishbone classic single-cycle initiator that drives the NN block's Wishbone slave port. A simple valid/ready command channel is converted into one Wishbone read or write per command, and the read data or write completion comes back on a valid/ready response channel. Used by the on-chip test sequencer and the self-test harness to load operands and fetch `NN_result` without a management core.

## Interface
- `ADDR_W`, 32, Wishbone address width
- `DATA_W`, 32, Wishbone data width
- `TIMEOUT_CYCLES`, 255, max cycles waiting for `wbm_ack_i` (used only with `NN_WBM_TIMEOUT_EN`; legal range 1..65535)

- `clk` in 1: single clock for all logic
- `rst_l` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`
- `cmd_we` in 1: 1 = write, 0 = read
- `cmd_adr` in ADDR_W: target byte address
- `cmd_dat` in DATA_W: write data
- `cmd_sel` in DATA_W/8: byte selects
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`
- `rsp_dat` out DATA_W: read data (0 for writes and errors)
- `rsp_err` out 1: transfer timed out
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1: Wishbone cycle, strobe, and write enable
- `wbm_adr_o` out ADDR_W, `wbm_dat_o` out DATA_W, `wbm_sel_o` out DATA_W/8: Wishbone address, write data, and byte selects
- `wbm_dat_i` in DATA_W, `wbm_ack_i` in 1: slave read data and acknowledge

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - `cmd_ready` = 1.
  - On handshake, register we/adr/dat/sel into the Wishbone output registers, set cyc = stb = 1, and go to BUS.
- BUS:
  - cyc/stb held high and all Wishbone outputs stable.
  - On `wbm_ack_i` = 1:
    - Capture `wbm_dat_i` into `rsp_dat` on reads, or load 0 on writes.
    - Set `rsp_err` = 0 and drop cyc/stb.
    - Go to RESP.
- RESP:
  - `rsp_valid` = 1, with `rsp_dat`/`rsp_err` stable.
  - On `rsp_ready`, go to IDLE.
- `cmd_ready` = 0 in BUS and RESP. Only one transfer is outstanding; there is no command buffering.
- `wbm_ack_i` outside BUS is ignored, and no state changes.
- `cmd_valid` in BUS/RESP is not consumed. The command must be held by the source.
- Reset, at any point including mid-transfer:
  - FSM returns to IDLE immediately.
  - cyc/stb/we and `rsp_valid`/`rsp_err` go to 0.
  - adr/dat/sel/`rsp_dat` go to 0.
  - `cmd_ready` goes to 1 once `rst_l` is released.

## Timing
- Cycle N: command handshake.
- Cycle N+1: `wbm_cyc_o`/`wbm_stb_o` high.
- Ack sampled high at cycle M ≥ N+1:
  - cycle M+1: cyc/stb low and `rsp_valid` high.
- Minimum command-to-response latency is 2 cycles.
- If `rsp_ready` is high in the first RESP cycle, `cmd_ready` is high the following cycle. The back-to-back issue interval is therefore 3 cycles minimum.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `NN_WBM_TIMEOUT_EN` defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`, cyc/stb drop and the FSM goes to RESP with `rsp_err` = 1 and `rsp_dat` = 0.
  - Ack in the same cycle as the terminal count wins: normal completion, `rsp_err` = 0.
- Not defined:
  - No counter is built.
  - BUS waits indefinitely for ack.
  - `rsp_err` is tied to 0.

## Structure
- Package `nn_wbm_pkg`: state enum (IDLE/BUS/RESP), default widths, and `NN_WBM_TO_W` = 16 counter width.
- Sub-module `nn_wbm_timeout`:
  - Clear, enable, and terminal-count output.
  - Instantiated only under `NN_WBM_TIMEOUT_EN`.

## Test plan
- Write `cmd_adr`=0x3000_0004, `cmd_dat`=0x3F80_0000, `cmd_sel`=0xF; slave acks in 1st BUS cycle -> cyc/stb/we high for exactly 1 cycle with matching adr/dat/sel; `rsp_valid` 2 cycles after handshake, `rsp_dat`=0, `rsp_err`=0.
- Read 0x3000_0010; slave acks after 3 wait cycles with `wbm_dat_i`=0x4040_0000 -> cyc held 4 cycles, `rsp_dat`=0x4040_0000; `rsp_ready` held low 5 cycles -> `rsp_valid`/`rsp_dat` stable, `cmd_ready`=0 throughout.
- Two queued commands with `rsp_ready`=1 -> second cyc rises exactly 3 cycles after the first; a spurious `wbm_ack_i` pulse while in IDLE -> no response generated.
- `NN_WBM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, slave never acks -> cyc drops after 4 BUS cycles, `rsp_err`=1, `rsp_dat`=0; repeat with ack on the 4th cycle -> `rsp_err`=0.
- `rst_l` pulsed low during BUS of a read -> cyc/stb/`rsp_valid` low in the same cycle (asynchronous), `cmd_ready`=1 after release, no response emitted for the aborted read.
